bb_mux_sel_ctrl: RTL

Sequencer that owns the select line of a generated-clock/reset mux cell and switches it safely on request. A switch runs as a fixed sequence: assert domain reset, gate the downstream clock, flip the select, settle, ungate, then release reset. It sits beside each clock/reset mux cell and is driven by the clock/reset control logic in the same clock domain.

---
 rtl/bb_mux_sel_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bb_mux_sel_ctrl.sv
// bb_mux_sel_ctrl
//   Sequencer that owns the select line of a clock/reset mux cell and changes
//   it only inside a safe window: hold the downstream domain in reset, gate its
//   clock, flip the select, let the mux settle, ungate, then release reset.
//
// Ports
//   clk      in   controller clock (free-running, not the muxed clock)
//   rst      in   asynchronous active-high reset
//   sw_req   in   single-cycle switch request pulse
//   sw_tgt   in   requested select value, sampled together with sw_req
//   sw_busy  out  high while a switch sequence is in progress
//   sw_done  out  one-cycle pulse when a request completes
//   sw_err   out  one-cycle pulse when a request is rejected (not idle)
//   mux_sel  out  select input of the mux cell (0 = ina, 1 = inb)
//   clk_en   out  downstream clock-gate enable
//   dom_rst  out  active-high reset for the downstream domain
//
// Every output comes straight from a flop. Each flop's next value is decoded
// from the next state, so the outputs line up with the state they belong to.
module bb_mux_sel_ctrl #(
  parameter int PRE_CYC    = 4,
  parameter int OFF_CYC    = 2,
  parameter int SETTLE_CYC = 4,
  parameter int POST_CYC   = 8,
  parameter bit RESET_SEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_req,
  input  logic sw_tgt,
  output logic sw_busy,
  output logic sw_done,
  output logic sw_err,
  output logic mux_sel,
  output logic clk_en,
  output logic dom_rst
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_POST   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // The shared counter is loaded with N-1 on state entry and the state is
  // left when it reads zero, so a state lasts exactly N cycles.
  localparam logic [7:0] PRE_LD    = 8'(PRE_CYC - 1);
  localparam logic [7:0] OFF_LD    = 8'(OFF_CYC - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] POST_LD   = 8'(POST_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tgt_q, tgt_d;
  logic       mux_sel_q, mux_sel_d;
  logic       clk_en_q, clk_en_d;
  logic       dom_rst_q, dom_rst_d;
  logic       sw_busy_q, sw_busy_d;
  logic       sw_done_q, sw_done_d;
  logic       sw_err_q, sw_err_d;
  logic       cnt_last;

  assign cnt_last = (cnt_q == 8'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    mux_sel_d = mux_sel_q;
    sw_done_d = 1'b0;
    // Anything arriving outside IDLE (DONE included) is turned away without
    // disturbing the running sequence.
    sw_err_d  = sw_req && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (sw_req) begin
          if (sw_tgt != mux_sel_q) begin
            state_d = S_PRE;
            cnt_d   = PRE_LD;
            tgt_d   = sw_tgt;
          end else begin
            // Already on the requested input: acknowledge, touch nothing.
            sw_done_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (cnt_last) begin
          state_d = S_GATE;
          cnt_d   = OFF_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GATE: begin
        if (cnt_last) begin
          // The only place the select moves: clock gated and domain in reset.
          state_d   = S_SETTLE;
          cnt_d     = SETTLE_LD;
          mux_sel_d = tgt_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_last) begin
          state_d = S_POST;
          cnt_d   = POST_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_POST: begin
        if (cnt_last) begin
          state_d   = S_DONE;
          sw_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output levels decoded from the state being entered.
    clk_en_d  = !((state_d == S_GATE) || (state_d == S_SETTLE));
    dom_rst_d = (state_d == S_PRE) || (state_d == S_GATE) ||
                (state_d == S_SETTLE) || (state_d == S_POST);
    sw_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      tgt_q     <= RESET_SEL;
      mux_sel_q <= RESET_SEL;
      clk_en_q  <= 1'b1;
      dom_rst_q <= 1'b1;
      sw_busy_q <= 1'b0;
      sw_done_q <= 1'b0;
      sw_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      mux_sel_q <= mux_sel_d;
      clk_en_q  <= clk_en_d;
      dom_rst_q <= dom_rst_d;
      sw_busy_q <= sw_busy_d;
      sw_done_q <= sw_done_d;
      sw_err_q  <= sw_err_d;
    end
  end

  assign sw_busy = sw_busy_q;
  assign sw_done = sw_done_q;
  assign sw_err  = sw_err_q;
  assign mux_sel = mux_sel_q;
  assign clk_en  = clk_en_q;
  assign dom_rst = dom_rst_q;

endmodule
